// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC-driven instruction fetch over req/ack with an in-order decode queue
module instruction_fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] Pc,
  input  logic        Flush,
  output logic        PcEn,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemRdata,
  input  logic        IMemAck,
  output logic [31:0] Inst,
  output logic [31:0] InstPc,
  output logic        InstFault,
  output logic        InstValid,
  input  logic        InstReady
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN, HALT} state_t;
  state_t state, state_nx;
  logic [31:0] addr_q, push_pc;
  logic [CW-1:0] count;
  logic [PW-1:0] head, tail;
  logic [31:0] q_pc [DEPTH];
  logic [31:0] q_inst [DEPTH];
  logic q_fault [DEPTH];
  logic idle, wt, dr, not_full, aligned, mem_push, push_fault, push, pop;
  // request, push and next-state decode; flush wins over everything else
  always_comb begin
    idle       = state == IDLE;
    wt         = state == WAIT;
    dr         = state == DRAIN;
    not_full   = count < FULL;
    aligned    = Pc[1:0] == 2'b00;
    IMemReq    = RESET_N && ((idle && not_full && !Flush && aligned) || wt || dr);
    IMemAddr   = idle ? Pc : addr_q;
    mem_push   = !Flush && IMemAck && ((idle && IMemReq) || wt);
    push_fault = idle && not_full && !Flush && !aligned;
    push       = mem_push || push_fault;
    push_pc    = idle ? Pc : addr_q;
    pop        = InstValid && InstReady && !Flush;
    PcEn       = RESET_N && (mem_push || Flush);
    state_nx   = Flush ? (((wt || dr) && !IMemAck) ? DRAIN : IDLE)
               : push_fault ? HALT
               : (idle && IMemReq && !IMemAck) ? WAIT
               : ((wt || dr) && IMemAck) ? IDLE : state;
  end
  // head-of-queue presentation, zeroed when empty
  always_comb begin
    InstValid = count != '0;
    Inst      = InstValid ? q_inst[head] : '0;
    InstPc    = InstValid ? q_pc[head] : '0;
    InstFault = InstValid && q_fault[head];
  end
  // FSM state and the address held while a request is outstanding
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= IDLE;
      addr_q <= '0;
    end else begin
      state  <= state_nx;
      addr_q <= (idle && IMemReq && !IMemAck) ? Pc : addr_q;
    end
  end
  // queue pointers and occupancy; a flush empties the queue outright
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (Flush) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      head  <= pop ? (head == LAST ? '0 : head + 1'b1) : head;
      tail  <= push ? (tail == LAST ? '0 : tail + 1'b1) : tail;
    end
  end
  // queue storage; contents only matter while counted as valid
  always_ff @(posedge CLK) begin
    if (push && !Flush) begin
      q_pc[tail]    <= push_pc;
      q_inst[tail]  <= push_fault ? NOP_INST : IMemRdata;
      q_fault[tail] <= push_fault;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed scoreboard bench for the fetch unit
module tb_instruction_fetch_unit;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } ent_t;
  logic        CLK = 1'b0, RESET_N = 1'b0, Flush = 1'b0, InstReady = 1'b0;
  logic [31:0] Pc = '0;
  logic        PcEn, IMemReq, IMemAck, InstFault, InstValid;
  logic [31:0] IMemAddr, IMemRdata, Inst, InstPc;
  logic        mem_en = 1'b0, force_bad = 1'b0, pc_load = 1'b0;
  logic [31:0] pc_val = '0, br_tgt = '0;
  int          lat = 0, wcnt;
  int          total = 0, bad = 0;
  ent_t        exp_q[$];

  instruction_fetch_unit dut (
    .CLK(CLK), .RESET_N(RESET_N), .Pc(Pc), .Flush(Flush), .PcEn(PcEn),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemRdata(IMemRdata), .IMemAck(IMemAck),
    .Inst(Inst), .InstPc(InstPc), .InstFault(InstFault), .InstValid(InstValid),
    .InstReady(InstReady)
  );

  always #5 CLK = ~CLK;

  // program counter model: load, branch target on Flush, else +4
  always @(posedge CLK) begin
    if (pc_load) Pc <= pc_val;
    else if (PcEn) Pc <= Flush ? br_tgt : Pc + 32'd4;
  end

  // memory model: acks after lat cycles of continuous request
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) wcnt <= 0;
    else wcnt <= (IMemReq && !IMemAck) ? wcnt + 1 : 0;
  end
  assign IMemAck   = mem_en && IMemReq && (wcnt >= lat);
  assign IMemRdata = force_bad ? 32'hDEADBEEF : {16'hC0DE, IMemAddr[15:0]};

  function automatic ent_t mk(input logic [31:0] p, input logic [31:0] i, input logic f);
    mk = '{pc: p, inst: i, fault: f};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] p);
    RESET_N = 1'b0;
    mem_en = 1'b0;
    Flush = 1'b0;
    force_bad = 1'b0;
    exp_q.delete();
    pc_load = 1'b1;
    pc_val = p;
    tick();
    tick();
    pc_load = 1'b0;
    RESET_N = 1'b1;
  endtask

  // scoreboard monitor: every accepted head entry must match the oldest expectation
  task automatic monitor();
    ent_t e;
    forever begin
      @(negedge CLK);
      if (RESET_N && InstValid && InstReady && !Flush) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_unexpected: got pc %h inst %h want no entry", InstPc, Inst);
        end else begin
          e = exp_q.pop_front();
          chk("pop_pc", InstPc, e.pc);
          chk("pop_inst", Inst, e.inst);
          chk("pop_fault", {31'b0, InstFault}, {31'b0, e.fault});
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    fork
      monitor();
    join_none
    InstReady = 1'b1;
    tick();
    tick();
    chk("rst_req", {31'b0, IMemReq}, 0);
    chk("rst_pcen", {31'b0, PcEn}, 0);
    chk("rst_valid", {31'b0, InstValid}, 0);
    chk("rst_fault", {31'b0, InstFault}, 0);
    chk("rst_inst", Inst, 0);
    chk("rst_instpc", InstPc, 0);

    // zero-wait streaming from 0x0
    do_reset(32'h0);
    lat = 0;
    InstReady = 1'b1;
    mem_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t1_addr", IMemAddr, 32'(4 * i));
      chk("t1_req", {31'b0, IMemReq}, 1);
      chk("t1_pcen", {31'b0, PcEn}, 1);
      chk("t1_valid", {31'b0, InstValid}, (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) chk("t1_instpc", InstPc, 32'(4 * (i - 1)));
      exp_q.push_back(mk(32'(4 * i), 32'hC0DE0000 | 32'(4 * i), 1'b0));
      tick();
    end
    mem_en = 1'b0;
    #1;
    chk("t1_stall_addr", IMemAddr, 32'hC);
    chk("t1_stall_pcen", {31'b0, PcEn}, 0);
    chk("t1_last_instpc", InstPc, 32'h8);
    tick();
    tick();

    // three-cycle memory latency at 0x10
    do_reset(32'h10);
    lat = 3;
    mem_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_req", {31'b0, IMemReq}, 1);
      chk("t2_addr", IMemAddr, 32'h10);
      chk("t2_pcen_wait", {31'b0, PcEn}, 0);
      tick();
    end
    #1;
    chk("t2_addr_ack", IMemAddr, 32'h10);
    chk("t2_pcen_ack", {31'b0, PcEn}, 1);
    exp_q.push_back(mk(32'h10, 32'hC0DE0010, 1'b0));
    tick();
    #1;
    chk("t2_pcen_after", {31'b0, PcEn}, 0);
    chk("t2_instpc", InstPc, 32'h10);
    tick();
    tick();

    // back-pressure fills the queue
    do_reset(32'h40);
    lat = 0;
    InstReady = 1'b0;
    mem_en = 1'b1;
    #1;
    chk("t3_addr0", IMemAddr, 32'h40);
    exp_q.push_back(mk(32'h40, 32'hC0DE0040, 1'b0));
    tick();
    #1;
    chk("t3_addr1", IMemAddr, 32'h44);
    chk("t3_req1", {31'b0, IMemReq}, 1);
    exp_q.push_back(mk(32'h44, 32'hC0DE0044, 1'b0));
    tick();
    #1;
    chk("t3_req_full", {31'b0, IMemReq}, 0);
    chk("t3_pcen_full", {31'b0, PcEn}, 0);
    tick();
    #1;
    chk("t3_req_full2", {31'b0, IMemReq}, 0);
    tick();
    InstReady = 1'b1;
    #1;
    chk("t3_req_popcyc", {31'b0, IMemReq}, 0);
    tick();
    mem_en = 1'b0;
    #1;
    chk("t3_req_resume", {31'b0, IMemReq}, 1);
    chk("t3_addr_resume", IMemAddr, 32'h48);
    tick();
    #1;
    chk("t3_empty", {31'b0, InstValid}, 0);
    tick();

    // flush while waiting; stale response must be drained
    do_reset(32'h20);
    lat = 0;
    InstReady = 1'b1;
    #1;
    chk("t4_addr", IMemAddr, 32'h20);
    tick();
    Flush = 1'b1;
    br_tgt = 32'h80;
    #1;
    chk("t4_pcen_flush", {31'b0, PcEn}, 1);
    tick();
    Flush = 1'b0;
    #1;
    chk("t4_drain_req", {31'b0, IMemReq}, 1);
    chk("t4_drain_addr", IMemAddr, 32'h20);
    chk("t4_drain_valid", {31'b0, InstValid}, 0);
    tick();
    mem_en = 1'b1;
    force_bad = 1'b1;
    #1;
    chk("t4_drop_pcen", {31'b0, PcEn}, 0);
    tick();
    force_bad = 1'b0;
    #1;
    chk("t4_new_addr", IMemAddr, 32'h80);
    chk("t4_new_pcen", {31'b0, PcEn}, 1);
    chk("t4_no_stale", {31'b0, InstValid}, 0);
    exp_q.push_back(mk(32'h80, 32'hC0DE0080, 1'b0));
    tick();
    mem_en = 1'b0;
    #1;
    chk("t4_instpc", InstPc, 32'h80);
    tick();

    // misaligned PC traps and halts until a branch
    do_reset(32'h102);
    lat = 0;
    InstReady = 1'b0;
    mem_en = 1'b1;
    #1;
    chk("t5_req", {31'b0, IMemReq}, 0);
    chk("t5_pcen", {31'b0, PcEn}, 0);
    exp_q.push_back(mk(32'h102, 32'h00000013, 1'b1));
    tick();
    #1;
    chk("t5_valid", {31'b0, InstValid}, 1);
    chk("t5_fault", {31'b0, InstFault}, 1);
    chk("t5_inst", Inst, 32'h13);
    chk("t5_halt_req", {31'b0, IMemReq}, 0);
    tick();
    InstReady = 1'b1;
    tick();
    #1;
    chk("t5_halt_pcen", {31'b0, PcEn}, 0);
    chk("t5_halt_valid", {31'b0, InstValid}, 0);
    tick();
    Flush = 1'b1;
    br_tgt = 32'h200;
    #1;
    chk("t5_flush_pcen", {31'b0, PcEn}, 1);
    chk("t5_flush_req", {31'b0, IMemReq}, 0);
    tick();
    Flush = 1'b0;
    #1;
    chk("t5_resume_addr", IMemAddr, 32'h200);
    chk("t5_resume_req", {31'b0, IMemReq}, 1);
    exp_q.push_back(mk(32'h200, 32'hC0DE0200, 1'b0));
    tick();
    mem_en = 1'b0;
    #1;
    chk("t5_instpc", InstPc, 32'h200);
    tick();

    // reset during an outstanding request with one entry queued
    do_reset(32'h300);
    lat = 0;
    InstReady = 1'b0;
    mem_en = 1'b1;
    #1;
    chk("t6_addr0", IMemAddr, 32'h300);
    exp_q.push_back(mk(32'h300, 32'hC0DE0300, 1'b0));
    tick();
    mem_en = 1'b0;
    #1;
    chk("t6_wait_addr", IMemAddr, 32'h304);
    tick();
    #1;
    chk("t6_valid_before", {31'b0, InstValid}, 1);
    #2;
    RESET_N = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_rst_valid", {31'b0, InstValid}, 0);
    chk("t6_rst_req", {31'b0, IMemReq}, 0);
    chk("t6_rst_pcen", {31'b0, PcEn}, 0);
    do_reset(32'h500);
    InstReady = 1'b1;
    mem_en = 1'b1;
    #1;
    chk("t6_restart_addr", IMemAddr, 32'h500);
    chk("t6_restart_req", {31'b0, IMemReq}, 1);
    exp_q.push_back(mk(32'h500, 32'hC0DE0500, 1'b0));
    tick();
    mem_en = 1'b0;
    #1;
    chk("t6_instpc", InstPc, 32'h500);
    tick();
    tick();

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
